// File: rtl/execute_stage.sv
// MIPS32 execute stage: operand forwarding, ALU, destination select and an
// iterative multiply/divide unit that owns HI/LO and stalls E while working.
module execute_stage #(
  parameter int unsigned MD_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  aluControlE,
  input  logic        aluSrcE,
  input  logic        regDstE,
  input  logic [31:0] rd1E,
  input  logic [31:0] rd2E,
  input  logic [4:0]  rtE,
  input  logic [4:0]  rdE,
  input  logic [31:0] signImmE,
  input  logic [1:0]  forwardAE,
  input  logic [1:0]  forwardBE,
  input  logic [31:0] aluOutM,
  input  logic [31:0] resultW,
  output logic [31:0] aluOutE,
  output logic [31:0] writeDataE,
  output logic [4:0]  writeRegE,
  output logic        stallE
);

  localparam int unsigned CNT_W = $clog2(MD_CYCLES);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1110;
  localparam logic [3:0] OP_MFHI = 4'b1100;
  localparam logic [3:0] OP_MFLO = 4'b1101;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_e;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [63:0]      acc_q, acc_d;        // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [31:0]      opnd_q, opnd_d;      // multiplicand or divisor magnitude
  logic [31:0]      dividend_q, dividend_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             div0_q, div0_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [31:0] src_a, fwd_b, src_b;
  logic        is_md, is_mfx;

  // Forwarding muxes; select 11 falls back to the register file.
  always_comb begin
    case (forwardAE)
      2'b10:   src_a = aluOutM;
      2'b01:   src_a = resultW;
      default: src_a = rd1E;
    endcase
    case (forwardBE)
      2'b10:   fwd_b = aluOutM;
      2'b01:   fwd_b = resultW;
      default: fwd_b = rd2E;
    endcase
  end

  assign src_b      = aluSrcE ? signImmE : fwd_b;
  assign writeDataE = fwd_b;
  assign writeRegE  = regDstE ? rdE : rtE;
  assign is_md      = (aluControlE[3:2] == 2'b10);
  assign is_mfx     = (aluControlE[3:1] == 3'b110);

  always_comb begin
    aluOutE = '0;
    case (aluControlE)
      OP_AND:  aluOutE = src_a & src_b;
      OP_OR:   aluOutE = src_a | src_b;
      OP_ADD:  aluOutE = src_a + src_b;
      OP_XOR:  aluOutE = src_a ^ src_b;
      OP_NOR:  aluOutE = ~(src_a | src_b);
      OP_SUB:  aluOutE = src_a - src_b;
      OP_SLT:  aluOutE = 32'(($signed(src_a) < $signed(src_b)) ? 1 : 0);
      OP_SLTU: aluOutE = 32'((src_a < src_b) ? 1 : 0);
      OP_MFHI: aluOutE = hi_q;
      OP_MFLO: aluOutE = lo_q;
      default: aluOutE = '0;
    endcase
  end

  assign stallE = ((state_q == IDLE) && is_md) || (state_q == BUSY) ||
                  (is_mfx && (state_q != IDLE) && (state_q != DONE));

  // Operand sign handling at capture: the iteration always runs on magnitudes.
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  assign a_neg = ~aluControlE[0] & src_a[31];
  assign b_neg = ~aluControlE[0] & fwd_b[31];
  assign a_mag = a_neg ? -src_a : src_a;
  assign b_mag = b_neg ? -fwd_b : fwd_b;

  // One shift-add or restoring-subtract iteration.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic [31:0] div_diff;
  logic        div_ge;
  logic [63:0] div_next;
  logic [63:0] step;

  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    div_shift = {acc_q[63:32], acc_q[31]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift[31:0] - opnd_q;
    div_next  = div_ge ? {div_diff, acc_q[30:0], 1'b1}
                       : {div_shift[31:0], acc_q[30:0], 1'b0};
    step      = is_div_q ? div_next : mul_next;
  end

  // Sign correction and divide-by-zero override of the final iteration.
  logic [63:0] prod_fix;
  logic [31:0] fin_hi, fin_lo;

  always_comb begin
    prod_fix = neg_lo_q ? -step : step;
    fin_hi   = prod_fix[63:32];
    fin_lo   = prod_fix[31:0];
    if (is_div_q) begin
      fin_lo = neg_lo_q ? -step[31:0]  : step[31:0];
      fin_hi = neg_hi_q ? -step[63:32] : step[63:32];
      if (div0_q) begin
        fin_hi = dividend_q;
        fin_lo = '1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    dividend_d = dividend_q;
    is_div_d   = is_div_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    div0_d     = div0_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      IDLE: begin
        if (is_md) begin
          state_d    = BUSY;
          count_d    = CNT_W'(MD_CYCLES - 1);
          acc_d      = {32'd0, a_mag};
          opnd_d     = b_mag;
          dividend_d = src_a;
          is_div_d   = aluControlE[1];
          neg_lo_d   = a_neg ^ b_neg;
          neg_hi_d   = a_neg;
          div0_d     = (fwd_b == 32'd0);
        end
      end
      BUSY: begin
        acc_d = step;
        if (count_q == '0) begin
          hi_d    = fin_hi;
          lo_d    = fin_lo;
          state_d = DONE;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      dividend_q <= '0;
      is_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      div0_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      dividend_q <= dividend_d;
      is_div_q   <= is_div_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      div0_q     <= div0_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

endmodule
